sort_result_serializer: RTL and testbench

SORT_RESULT_SERIALIZER -- requirements
Module: sort_result_serializer

---
 rtl/sort_ser_pkg.sv | 17 +
 rtl/sort_ser_slot_buf.sv | 80 ++++++++
 rtl/sort_result_serializer.sv | 157 +++++++++++++++
 tb/tb_sort_result_serializer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_ser_pkg.sv
// Shared types for the sort result serializer.
// Reader states, slot states and drop counter width.
package sort_ser_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/sort_ser_slot_buf.sv
// Two-slot ping-pong vector store for the serializer.
// Filled alternately, drained in FIFO order.
module sort_ser_slot_buf
   import sort_ser_pkg::*;
#(
   parameter int LOG_INPUT_NUM = 4,
   parameter int DATA_WIDTH    = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wr_en_i,
   input  logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] wr_data_i,
   input  logic rd_free_i,
   output logic rd_full_o,
   output logic oth_full_o,
   output logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] rd_vec_o,
   output logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] oth_vec_o,
   output logic drop_o,
   output logic busy_o
);

   localparam int VW = DATA_WIDTH << LOG_INPUT_NUM;

   logic [VW-1:0] slot_q [2];
   slot_state_e   st_q [2];
   slot_state_e   st_d [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic          wr_ok, wr_acc;
   logic          busy_q;

   // Free first so a slot released this cycle can be refilled at once
   always_comb begin
      st_d     = st_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      wr_ok    = (st_q[wr_ptr_q] == EMPTY) ||
                 (rd_free_i && (rd_ptr_q == wr_ptr_q));
      wr_acc   = wr_en_i && wr_ok;
      if (rd_free_i) begin
         st_d[rd_ptr_q] = EMPTY;
         rd_ptr_d       = ~rd_ptr_q;
      end
      if (wr_acc) begin
         st_d[wr_ptr_q] = FULL;
         wr_ptr_d       = ~wr_ptr_q;
      end
   end

   // Slot flags, pointers and registered busy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q[0]  <= EMPTY;
         st_q[1]  <= EMPTY;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         busy_q   <= (st_d[0] == FULL) || (st_d[1] == FULL);
      end
   end

   // Vector payload capture; contents are don't-care while EMPTY
   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_acc) begin
         slot_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_full_o  = (st_q[rd_ptr_q] == FULL);
   assign oth_full_o = (st_q[~rd_ptr_q] == FULL);
   assign rd_vec_o   = slot_q[rd_ptr_q];
   assign oth_vec_o  = slot_q[~rd_ptr_q];
   assign drop_o     = wr_en_i && !wr_ok;
   assign busy_o     = busy_q;

endmodule

// File: rtl/sort_result_serializer.sv
// Serializes sorted vectors into one element per beat.
// Define SORT_SER_DROP_CNT_EN to add the drop_count output.
module sort_result_serializer
   import sort_ser_pkg::*;
#(
   parameter int LOG_INPUT_NUM = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int REVERSE       = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] in_data,
   output logic out_valid,
   input  logic out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [LOG_INPUT_NUM-1:0] out_index,
   output logic out_last,
   output logic overflow,
`ifdef SORT_SER_DROP_CNT_EN
   output logic [DROP_CNT_W-1:0] drop_count,
`endif
   output logic busy
);

   localparam int VW = DATA_WIDTH << LOG_INPUT_NUM;
   localparam logic [LOG_INPUT_NUM-1:0] FIRST_IDX =
      (REVERSE != 0) ? '1 : '0;
   localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX =
      (REVERSE != 0) ? '0 : '1;

   typedef logic [LOG_INPUT_NUM-1:0] idx_t;

   function automatic logic [DATA_WIDTH-1:0] elem(
      input logic [VW-1:0] v,
      input idx_t          i
   );
      return v[int'(i)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   rd_state_e             state_q, state_d;
   idx_t                  cnt_q, cnt_d, cnt_nxt;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ovf_q;
   logic                  xfer, free;
   logic                  rd_full, oth_full, drop;
   logic [VW-1:0]         rd_vec, oth_vec;

   assign xfer    = valid_q && out_ready;
   assign free    = xfer && last_q;
   assign cnt_nxt = (REVERSE != 0) ? cnt_q - 1'b1 : cnt_q + 1'b1;

   sort_ser_slot_buf #(
      .LOG_INPUT_NUM (LOG_INPUT_NUM),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_buf (
      .clk_i      (clk),
      .rst_i      (rst),
      .wr_en_i    (in_valid),
      .wr_data_i  (in_data),
      .rd_free_i  (free),
      .rd_full_o  (rd_full),
      .oth_full_o (oth_full),
      .rd_vec_o   (rd_vec),
      .oth_vec_o  (oth_vec),
      .drop_o     (drop),
      .busy_o     (busy)
   );

   // Reader FSM: picks the element presented in the next cycle.
   // A fresh vector is taken straight from in_data so the first
   // beat appears one cycle after in_valid.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (rd_full) begin
               state_d = STREAM;
               valid_d = 1'b1;
               cnt_d   = FIRST_IDX;
               data_d  = elem(rd_vec, FIRST_IDX);
            end else if (in_valid) begin
               state_d = STREAM;
               valid_d = 1'b1;
               cnt_d   = FIRST_IDX;
               data_d  = elem(in_data, FIRST_IDX);
            end
         end
         STREAM: begin
            if (xfer && !last_q) begin
               cnt_d  = cnt_nxt;
               data_d = elem(rd_vec, cnt_nxt);
            end else if (free && oth_full) begin
               cnt_d  = FIRST_IDX;
               data_d = elem(oth_vec, FIRST_IDX);
            end else if (free && in_valid) begin
               cnt_d  = FIRST_IDX;
               data_d = elem(in_data, FIRST_IDX);
            end else if (free) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      last_d = valid_d && (cnt_d == LAST_IDX);
   end

   // Registered outputs and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ovf_q   <= ovf_q | drop;
      end
   end

`ifdef SORT_SER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q;

   // Saturating count of dropped vectors
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign drop_count = drop_cnt_q;
`endif

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_index = cnt_q;
   assign out_last  = last_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_sort_result_serializer.sv
// Bench for sort_result_serializer: forward and reversed
// instances checked against a queue-based vector model.
module tb_sort_result_serializer;

   typedef logic [127:0] vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   vec_t       in_data;
   logic       out_ready;

   logic       f_valid, f_last, f_ovf, f_busy;
   logic [7:0] f_data;
   logic [3:0] f_idx;
   logic       r_valid, r_last, r_ovf, r_busy;
   logic [7:0] r_data;
   logic [3:0] r_idx;
`ifdef SORT_SER_DROP_CNT_EN
   logic [15:0] f_dcnt, r_dcnt;
`endif

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   sort_result_serializer #(
      .LOG_INPUT_NUM (4),
      .DATA_WIDTH    (8),
      .REVERSE       (0)
   ) u_fwd (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (f_valid),
      .out_ready  (out_ready),
      .out_data   (f_data),
      .out_index  (f_idx),
      .out_last   (f_last),
      .overflow   (f_ovf),
`ifdef SORT_SER_DROP_CNT_EN
      .drop_count (f_dcnt),
`endif
      .busy       (f_busy)
   );

   sort_result_serializer #(
      .LOG_INPUT_NUM (4),
      .DATA_WIDTH    (8),
      .REVERSE       (1)
   ) u_rev (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (r_valid),
      .out_ready  (out_ready),
      .out_data   (r_data),
      .out_index  (r_idx),
      .out_last   (r_last),
      .overflow   (r_ovf),
`ifdef SORT_SER_DROP_CNT_EN
      .drop_count (r_dcnt),
`endif
      .busy       (r_busy)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of held vectors, head position
   vec_t        mq[$];
   int          pos = 0;
   bit          m_ovf = 0;
   logic [15:0] m_drops = '0;
   bit          m_rst = 0;
   bit          model_ok = 0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         pos      = 0;
         m_ovf    = 0;
         m_drops  = '0;
         m_rst    = 1;
         model_ok = 1;
      end else if (model_ok) begin
         m_rst = 0;
         if (mq.size() > 0 && out_ready) begin
            pos++;
            if (pos == 16) begin
               void'(mq.pop_front());
               pos = 0;
            end
         end
         if (in_valid) begin
            if (mq.size() < 2) begin
               mq.push_back(in_data);
            end else begin
               m_ovf = 1;
               if (m_drops != 16'hFFFF) m_drops++;
            end
         end
      end
   end

   // Per-cycle compare of both instances against the model
   always @(negedge clk) begin
      if (model_ok) begin
         bit   ev;
         vec_t h;
         ev = (mq.size() > 0);
         chk("fwd_valid", 32'(f_valid), 32'(ev));
         chk("rev_valid", 32'(r_valid), 32'(ev));
         chk("fwd_busy", 32'(f_busy), 32'(ev));
         chk("rev_busy", 32'(r_busy), 32'(ev));
         chk("fwd_ovf", 32'(f_ovf), 32'(m_ovf));
         chk("rev_ovf", 32'(r_ovf), 32'(m_ovf));
`ifdef SORT_SER_DROP_CNT_EN
         chk("fwd_dcnt", 32'(f_dcnt), 32'(m_drops));
         chk("rev_dcnt", 32'(r_dcnt), 32'(m_drops));
`endif
         if (ev) begin
            h = mq[0];
            chk("fwd_data", 32'(f_data),
                32'(h[pos*8 +: 8]));
            chk("fwd_idx", 32'(f_idx), 32'(pos));
            chk("fwd_last", 32'(f_last), 32'(pos == 15));
            chk("rev_data", 32'(r_data),
                32'(h[(15-pos)*8 +: 8]));
            chk("rev_idx", 32'(r_idx), 32'(15 - pos));
            chk("rev_last", 32'(r_last), 32'(pos == 15));
         end else begin
            chk("fwd_last_idle", 32'(f_last), 32'd0);
            chk("rev_last_idle", 32'(r_last), 32'd0);
            if (m_rst) begin
               chk("fwd_rst_data", 32'(f_data), 32'd0);
               chk("fwd_rst_idx", 32'(f_idx), 32'd0);
               chk("rev_rst_data", 32'(r_data), 32'd0);
               chk("rev_rst_idx", 32'(r_idx), 32'd0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v);
      in_valid = 1'b1;
      in_data  = v;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic vec_t ramp(input logic [7:0] base);
      vec_t v;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = base + 8'(i);
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int nv;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_valid", 32'(f_valid), 32'd0);
      chk("rst_busy", 32'(f_busy), 32'd0);
      chk("rst_ovf", 32'(f_ovf), 32'd0);
      chk("rst_data", 32'(f_data), 32'd0);
      rst = 1'b0;
      step();

      // Single ramp, ready held high
      out_ready = 1'b1;
      send(ramp(8'h00));
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         chk("ramp_data", 32'(f_data), 32'(b));
         chk("ramp_rdata", 32'(r_data), 32'(15 - b));
         chk("ramp_ridx", 32'(r_idx), 32'(15 - b));
         if (b == 15) begin
            chk("ramp_last", 32'(f_last), 32'd1);
            chk("ramp_rlast", 32'(r_last), 32'd1);
         end
         step();
      end
      @(negedge clk);
      chk("ramp_busy_end", 32'(f_busy), 32'd0);
      step();

      // Ready toggling
      send(ramp(8'h40));
      for (int c = 0; c < 40; c++) begin
         out_ready = c[0];
         step();
      end
      out_ready = 1'b1;
      repeat (4) step();

      // In_valid coinciding with last of A while both full
      do_reset();
      out_ready = 1'b0;
      send(ramp(8'h80));
      send(ramp(8'h90));
      step();
      out_ready = 1'b1;
      repeat (15) step();
      send(ramp(8'hA0));
      @(negedge clk);
      chk("coinc_ovf", 32'(f_ovf), 32'd0);
      chk("coinc_busy", 32'(f_busy), 32'd1);
      repeat (40) step();

      // Three back-to-back vectors while stalled
      do_reset();
      out_ready = 1'b0;
      send(ramp(8'h10));
      send(ramp(8'h20));
      send(ramp(8'h30));
      @(negedge clk);
      chk("abc_ovf", 32'(f_ovf), 32'd1);
`ifdef SORT_SER_DROP_CNT_EN
      chk("abc_dcnt", 32'(f_dcnt), 32'd1);
`endif
      step();
      out_ready = 1'b1;
      nv = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (f_valid) nv++;
         step();
      end
      chk("ab_beats", 32'(nv), 32'd32);

      // Reset at beat 5
      do_reset();
      out_ready = 1'b1;
      send(ramp(8'h00));
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(f_valid), 32'd0);
      step();
      send(ramp(8'h50));
      @(negedge clk);
      chk("fresh_data", 32'(f_data), 32'h50);
      chk("fresh_idx", 32'(f_idx), 32'd0);
      repeat (20) step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 499) == 0);
         in_valid  = ($urandom_range(0, 5) == 0);
         in_data   = rnd_vec();
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
